// File: rtl/spatz_simd_lane_sequencer_if.sv
// Shared operation/element-width types and the handshake bundle that connects the lane
// sequencer to the VFU issue logic on one side and the combinational SIMD lane on the other.
package spatz_pkg;

  typedef enum logic [3:0] {
    VADD  = 4'd0,
    VSUB  = 4'd1,
    VMUL  = 4'd2,
    VMULH = 4'd3,
    VMACC = 4'd4,
    VADC  = 4'd5,
    VSBC  = 4'd6,
    VMADC = 4'd7,
    VMSBC = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    EW_8  = 2'd0,
    EW_16 = 2'd1,
    EW_32 = 2'd2,
    EW_64 = 2'd3
  } vew_e;

endpackage

interface spatz_simd_lane_sequencer_if #(
  parameter int Width = 32,
  parameter int MaxVl = 256
);
  localparam int VlW = $clog2(MaxVl + 1);

  logic              flush_i;
  logic              op_valid_i;
  logic              op_ready_o;
  spatz_pkg::op_e    op_i;
  logic [VlW-1:0]    vl_i;
  logic              is_signed_i;
  spatz_pkg::vew_e   sew_i;
  logic              opnd_valid_i;
  logic              opnd_ready_o;
  logic [Width-1:0]  opnd_s1_i;
  logic [Width-1:0]  opnd_s2_i;
  logic [Width-1:0]  opnd_d_i;
  logic              opnd_carry_i;
  spatz_pkg::op_e    lane_op_o;
  logic [Width-1:0]  lane_s1_o;
  logic [Width-1:0]  lane_s2_o;
  logic [Width-1:0]  lane_d_o;
  logic              lane_signed_o;
  logic              lane_carry_o;
  spatz_pkg::vew_e   lane_sew_o;
  logic [Width-1:0]  lane_result_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [Width-1:0]  res_o;
  logic              res_last_o;
  logic              busy_o;
  logic              done_o;

  // The environment side: issue logic, lane and result consumer.
  modport master (
    output flush_i, op_valid_i, op_i, vl_i, is_signed_i, sew_i,
    output opnd_valid_i, opnd_s1_i, opnd_s2_i, opnd_d_i, opnd_carry_i,
    output lane_result_i, res_ready_i,
    input  op_ready_o, opnd_ready_o,
    input  lane_op_o, lane_s1_o, lane_s2_o, lane_d_o, lane_signed_o, lane_carry_o, lane_sew_o,
    input  res_valid_o, res_o, res_last_o, busy_o, done_o
  );

  modport slave (
    input  flush_i, op_valid_i, op_i, vl_i, is_signed_i, sew_i,
    input  opnd_valid_i, opnd_s1_i, opnd_s2_i, opnd_d_i, opnd_carry_i,
    input  lane_result_i, res_ready_i,
    output op_ready_o, opnd_ready_o,
    output lane_op_o, lane_s1_o, lane_s2_o, lane_d_o, lane_signed_o, lane_carry_o, lane_sew_o,
    output res_valid_o, res_o, res_last_o, busy_o, done_o
  );

endinterface

// File: rtl/spatz_simd_lane_sequencer.sv
// Streams vl operand tuples of one vector instruction through the combinational SIMD lane and
// registers each lane result into a single-entry valid/ready output stage tagged with last.
module spatz_simd_lane_sequencer #(
  parameter int Width = 32,
  parameter int MaxVl = 256
) (
  input logic                        clk_i,
  input logic                        rst_i,
  spatz_simd_lane_sequencer_if.slave bus
);
  import spatz_pkg::*;

  localparam int VlW = $clog2(MaxVl + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [VlW-1:0]   r_cnt;
  logic [VlW-1:0]   r_vl;
  op_e              r_op;
  logic             r_signed;
  vew_e             r_sew;
  logic [Width-1:0] r_res;
  logic             r_res_valid;
  logic             r_res_last;
  logic             r_done;
  logic             w_op_fire;
  logic             w_opnd_fire;
  logic             w_res_fire;
  logic             w_is_last;
  logic             w_done_next;

  // Operands are only taken when the output stage is empty or drains this same cycle.
  assign bus.op_ready_o   = (r_state == IDLE) & ~bus.flush_i;
  assign bus.opnd_ready_o = (r_state == RUN) & ~bus.flush_i & (~r_res_valid | bus.res_ready_i);

  assign w_op_fire   = bus.op_valid_i & bus.op_ready_o;
  assign w_opnd_fire = bus.opnd_valid_i & bus.opnd_ready_o;
  assign w_res_fire  = r_res_valid & bus.res_ready_i;
  assign w_is_last   = (r_cnt == r_vl - VlW'(1));

  assign bus.lane_op_o     = r_op;
  assign bus.lane_signed_o = r_signed;
  assign bus.lane_sew_o    = r_sew;
  assign bus.lane_s1_o     = bus.opnd_s1_i;
  assign bus.lane_s2_o     = bus.opnd_s2_i;
  assign bus.lane_d_o      = bus.opnd_d_i;
  assign bus.lane_carry_o  = bus.opnd_carry_i;

  assign bus.res_valid_o = r_res_valid;
  assign bus.res_o       = r_res;
  assign bus.res_last_o  = r_res_last;
  assign bus.busy_o      = (r_state != IDLE);
  assign bus.done_o      = r_done;

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    if (!bus.flush_i) begin
      unique case (r_state)
        IDLE: begin
          if (w_op_fire) begin
            if (bus.vl_i == '0) w_done_next = 1'b1;
            else                w_state_next = RUN;
          end
        end
        RUN: begin
          if (w_opnd_fire && w_is_last) w_state_next = DRAIN;
        end
        DRAIN: begin
          if (w_res_fire && r_res_last) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end else begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op     <= VADD;
      r_signed <= 1'b0;
      r_sew    <= EW_8;
      r_vl     <= '0;
    end else if (w_op_fire) begin
      r_op     <= bus.op_i;
      r_signed <= bus.is_signed_i;
      r_sew    <= bus.sew_i;
      r_vl     <= bus.vl_i;
    end
  end

  // The counter stops at vl because operands are refused outside RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      r_cnt <= '0;
    end else if (w_op_fire) begin
      r_cnt <= '0;
    end else if (w_opnd_fire) begin
      r_cnt <= r_cnt + VlW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res_valid <= 1'b0;
      r_res       <= '0;
      r_res_last  <= 1'b0;
    end else if (bus.flush_i) begin
      r_res_valid <= 1'b0;
    end else if (w_opnd_fire) begin
      r_res_valid <= 1'b1;
      r_res       <= bus.lane_result_i;
      r_res_last  <= w_is_last;
    end else if (w_res_fire) begin
      r_res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_op_fire) begin
      assert (bus.vl_i <= VlW'(MaxVl));
    end
  end

endmodule
